// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with an optional two-entry skid buffer,
// synchronous flush and per-stage stall/transfer performance counters.
module pipe_stage_skid #(
  parameter int WIDTH = 64,
  parameter bit SKID  = 1'b1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   xfer_cnt_q, xfer_cnt_d;
  logic               accept;
  logic               fire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v);
    return v + CNT_W'(1);
  endfunction

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = m_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_cnt_q;
  assign xfer_cnt  = xfer_cnt_q;

  assign accept = in_valid && in_ready;
  assign fire   = out_valid && out_ready;

  // Occupancy state machine; flush empties the stage but leaves M/S stale.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            m_d     = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && fire) begin
            m_d = in_data;
          end else if (accept && SKID) begin
            s_d     = in_data;
            state_d = ST_FULL;
          end else if (fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (fire) begin
            m_d     = s_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Counters ignore flush; only reset clears them.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    xfer_cnt_d  = xfer_cnt_q;
    if (out_valid && !out_ready) stall_cnt_d = sat_inc(stall_cnt_q);
    if (fire)                    xfer_cnt_d  = wrap_inc(xfer_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      m_q         <= '0;
      s_q         <= '0;
      stall_cnt_q <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      s_q         <= s_d;
      stall_cnt_q <= stall_cnt_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  generate
    if (SKID) begin : g_skid
      // Registered ready breaks the out_ready -> in_ready combinational path.
      logic in_ready_q, in_ready_d;
      always_comb begin
        in_ready_d = (state_d != ST_FULL);
      end
      always_ff @(posedge clk) begin
        if (reset) in_ready_q <= 1'b1;
        else       in_ready_q <= in_ready_d;
      end
      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: skid mode (A), combinational-ready mode (B)
// and a narrow-counter skid instance (C) for saturation/wrap.
module tb_pipe_stage_skid;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
  logic [7:0] a_in_data = 0, a_out_data;
  logic [1:0] a_occ;
  logic [15:0] a_stall, a_xfer;

  logic b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
  logic [7:0] b_in_data = 0, b_out_data;
  logic [1:0] b_occ;
  logic [7:0] b_stall, b_xfer;

  logic c_flush = 0, c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0;
  logic [7:0] c_in_data = 0, c_out_data;
  logic [1:0] c_occ;
  logic [3:0] c_stall, c_xfer;

  pipe_stage_skid #(.WIDTH(8), .SKID(1'b1), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .stall_cnt(a_stall), .xfer_cnt(a_xfer));

  pipe_stage_skid #(.WIDTH(8), .SKID(1'b0), .CNT_W(8)) u_b (
    .clk(clk), .reset(reset), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ), .stall_cnt(b_stall), .xfer_cnt(b_xfer));

  pipe_stage_skid #(.WIDTH(8), .SKID(1'b1), .CNT_W(4)) u_c (
    .clk(clk), .reset(reset), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .occupancy(c_occ), .stall_cnt(c_stall), .xfer_cnt(c_xfer));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    cmp_cnt++; if (a_out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_a_valid got %0h want 0", a_out_valid); end
    cmp_cnt++; if (a_occ !== 2'd0) begin err_cnt++; $display("FAIL rst_a_occ got %0h want 0", a_occ); end
    cmp_cnt++; if (a_in_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_a_ready got %0h want 1", a_in_ready); end
    cmp_cnt++; if (a_out_data !== 8'h00) begin err_cnt++; $display("FAIL rst_a_data got %0h want 0", a_out_data); end
    cmp_cnt++; if (a_stall !== 16'd0 || a_xfer !== 16'd0) begin err_cnt++; $display("FAIL rst_a_cnt got %0h/%0h want 0/0", a_stall, a_xfer); end
    cmp_cnt++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_b got rdy %0h vld %0h want 1/0", b_in_ready, b_out_valid); end
    cmp_cnt++; if (c_stall !== 4'd0 || c_xfer !== 4'd0 || c_in_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_c got %0h/%0h/%0h want 0/0/1", c_stall, c_xfer, c_in_ready); end
  endtask

  task automatic test_streaming();
    logic [7:0] vals [3];
    vals[0] = 8'h10; vals[1] = 8'h11; vals[2] = 8'h12;
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in_data = vals[i];
      step();
      cmp_cnt++; if (a_out_valid !== 1'b1 || a_out_data !== vals[i]) begin err_cnt++; $display("FAIL stream_data[%0d] got %0h/%0h want 1/%0h", i, a_out_valid, a_out_data, vals[i]); end
      cmp_cnt++; if (a_occ !== 2'd1) begin err_cnt++; $display("FAIL stream_occ[%0d] got %0d want 1", i, a_occ); end
    end
    a_in_valid = 1'b0;
    step();
    cmp_cnt++; if (a_xfer !== 16'd3) begin err_cnt++; $display("FAIL stream_xfer got %0d want 3", a_xfer); end
    cmp_cnt++; if (a_stall !== 16'd0) begin err_cnt++; $display("FAIL stream_stall got %0d want 0", a_stall); end
    cmp_cnt++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin err_cnt++; $display("FAIL stream_drain got %0h/%0d want 0/0", a_out_valid, a_occ); end
  endtask

  task automatic test_skid_fill();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 8'h0A;
    step();
    cmp_cnt++; if (a_occ !== 2'd1 || a_in_ready !== 1'b1) begin err_cnt++; $display("FAIL skid_one got occ %0d rdy %0h want 1/1", a_occ, a_in_ready); end
    a_in_data = 8'h0B;
    step();
    a_in_valid = 1'b0;
    cmp_cnt++; if (a_occ !== 2'd2) begin err_cnt++; $display("FAIL skid_full_occ got %0d want 2", a_occ); end
    cmp_cnt++; if (a_in_ready !== 1'b0) begin err_cnt++; $display("FAIL skid_full_ready got %0h want 0", a_in_ready); end
    step();
    cmp_cnt++; if (a_out_data !== 8'h0A || a_stall !== 16'd2) begin err_cnt++; $display("FAIL skid_hold got %0h/%0d want a/2", a_out_data, a_stall); end
    a_out_ready = 1'b1;
    step();
    cmp_cnt++; if (a_out_data !== 8'h0B || a_occ !== 2'd1) begin err_cnt++; $display("FAIL skid_second got %0h/%0d want b/1", a_out_data, a_occ); end
    cmp_cnt++; if (a_in_ready !== 1'b1) begin err_cnt++; $display("FAIL skid_ready_back got %0h want 1", a_in_ready); end
    step();
    cmp_cnt++; if (a_out_valid !== 1'b0 || a_xfer !== 16'd5 || a_stall !== 16'd2) begin err_cnt++; $display("FAIL skid_drain got %0h/%0d/%0d want 0/5/2", a_out_valid, a_xfer, a_stall); end
  endtask

  task automatic test_flush();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 8'h0C;
    step();
    a_in_data = 8'h0D;
    step();
    cmp_cnt++; if (a_occ !== 2'd2) begin err_cnt++; $display("FAIL flush_pre_occ got %0d want 2", a_occ); end
    a_flush   = 1'b1;
    a_in_data = 8'h0E;
    step();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    cmp_cnt++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_in_ready !== 1'b1) begin err_cnt++; $display("FAIL flush_full got %0h/%0d/%0h want 0/0/1", a_out_valid, a_occ, a_in_ready); end
    cmp_cnt++; if (a_stall !== 16'd4 || a_xfer !== 16'd5) begin err_cnt++; $display("FAIL flush_cnt got %0d/%0d want 4/5", a_stall, a_xfer); end
    step();
    cmp_cnt++; if (a_out_valid !== 1'b0 || a_out_data === 8'h0E) begin err_cnt++; $display("FAIL flush_leak got %0h/%0h want 0/not e", a_out_valid, a_out_data); end
    // Flush in ONE with a simultaneous accept and fire.
    a_in_valid = 1'b1;
    a_in_data  = 8'h21;
    step();
    a_flush     = 1'b1;
    a_out_ready = 1'b1;
    a_in_data   = 8'h22;
    step();
    a_flush     = 1'b0;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    cmp_cnt++; if (a_out_valid !== 1'b0 || a_xfer !== 16'd6 || a_out_data !== 8'h21) begin err_cnt++; $display("FAIL flush_fire got %0h/%0d/%0h want 0/6/21", a_out_valid, a_xfer, a_out_data); end
  endtask

  task automatic test_comb_backpressure();
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_data   = 8'h5A;
    step();
    b_in_valid = 1'b0;
    cmp_cnt++; if (b_out_valid !== 1'b1 || b_out_data !== 8'h5A) begin err_cnt++; $display("FAIL cbp_load got %0h/%0h want 1/5a", b_out_valid, b_out_data); end
    cmp_cnt++; if (b_in_ready !== 1'b0) begin err_cnt++; $display("FAIL cbp_rdy_lo got %0h want 0", b_in_ready); end
    b_out_ready = 1'b1;
    #1;
    cmp_cnt++; if (b_in_ready !== 1'b1) begin err_cnt++; $display("FAIL cbp_rdy_follow_hi got %0h want 1", b_in_ready); end
    b_out_ready = 1'b0;
    #1;
    cmp_cnt++; if (b_in_ready !== 1'b0) begin err_cnt++; $display("FAIL cbp_rdy_follow_lo got %0h want 0", b_in_ready); end
    step();
    cmp_cnt++; if (b_out_data !== 8'h5A || b_occ !== 2'd1 || b_stall !== 8'd1) begin err_cnt++; $display("FAIL cbp_hold got %0h/%0d/%0d want 5a/1/1", b_out_data, b_occ, b_stall); end
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_data   = 8'h61;
    step();
    b_in_valid = 1'b0;
    cmp_cnt++; if (b_out_data !== 8'h61 || b_xfer !== 8'd1 || b_occ !== 2'd1) begin err_cnt++; $display("FAIL cbp_fwd got %0h/%0d/%0d want 61/1/1", b_out_data, b_xfer, b_occ); end
    step();
    cmp_cnt++; if (b_out_valid !== 1'b0 || b_xfer !== 8'd2 || b_stall !== 8'd1) begin err_cnt++; $display("FAIL cbp_drain got %0h/%0d/%0d want 0/2/1", b_out_valid, b_xfer, b_stall); end
  endtask

  task automatic test_saturation_wrap();
    c_out_ready = 1'b0;
    c_in_valid  = 1'b1;
    c_in_data   = 8'h01;
    step();
    c_in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    cmp_cnt++; if (c_stall !== 4'd15) begin err_cnt++; $display("FAIL sat_stall got %0d want 15", c_stall); end
    c_out_ready = 1'b1;
    c_in_valid  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      c_in_data = 8'(8'h40 + i);
      step();
    end
    c_in_valid = 1'b0;
    cmp_cnt++; if (c_xfer !== 4'd1) begin err_cnt++; $display("FAIL wrap_xfer got %0d want 1", c_xfer); end
    cmp_cnt++; if (c_out_data !== 8'h50 || c_stall !== 4'd15) begin err_cnt++; $display("FAIL wrap_data got %0h/%0d want 50/15", c_out_data, c_stall); end
    step();
    c_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 8'h31;
    step();
    a_in_data = 8'h32;
    step();
    a_in_valid = 1'b0;
    step();
    step();
    cmp_cnt++; if (a_occ !== 2'd2 || a_stall !== 16'd7) begin err_cnt++; $display("FAIL rmid_pre got %0d/%0d want 2/7", a_occ, a_stall); end
    reset       = 1'b1;
    a_flush     = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = 8'h99;
    a_out_ready = 1'b1;
    step();
    reset       = 1'b0;
    a_flush     = 1'b0;
    a_out_ready = 1'b0;
    cmp_cnt++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_in_ready !== 1'b1 || a_out_data !== 8'h00) begin err_cnt++; $display("FAIL rmid_state got %0h/%0d/%0h/%0h want 0/0/1/0", a_out_valid, a_occ, a_in_ready, a_out_data); end
    cmp_cnt++; if (a_stall !== 16'd0 || a_xfer !== 16'd0) begin err_cnt++; $display("FAIL rmid_cnt got %0d/%0d want 0/0", a_stall, a_xfer); end
    a_in_data = 8'h33;
    step();
    a_in_valid = 1'b0;
    cmp_cnt++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h33) begin err_cnt++; $display("FAIL rmid_after got %0h/%0h want 1/33", a_out_valid, a_out_data); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_skid_fill();
    test_flush();
    test_comb_backpressure();
    test_saturation_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised valid/ready pipeline stage register that replaces the ad-hoc `done`/`valid` latches between the fetch, decode, execute, memory and write-back stages. It carries an opaque payload of `WIDTH` bits. The payload is typically a packed stage bundle: instruction, PC, operands and control-signal struct. The stage provides full-throughput backpressure through an optional two-entry skid buffer, a synchronous flush for branch/jump redirect, and per-stage performance counters.

## Interface
Parameters:
- `WIDTH`, default 64: payload width in bits, must be ≥ 1.
- `SKID`, default 1: buffer mode.
  - 1: two-entry skid buffer with registered `in_ready`.
  - 0: single register with combinational `in_ready`.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, synchronous, active-high.
- `flush`, input, 1: discard all held entries. Synchronous; highest priority after reset.
- `in_valid`, input, 1: upstream payload valid.
- `in_ready`, output, 1: stage can accept a payload this cycle.
- `in_data`, input, `WIDTH`: upstream payload.
- `out_valid`, output, 1: payload available to downstream.
- `out_ready`, input, 1: downstream accepts the payload this cycle.
- `out_data`, output, `WIDTH`: payload, driven from the main register.
- `occupancy`, output, 2: number of held entries (0..2).
- `stall_cnt`, output, `CNT_W`: cycles with `out_valid && !out_ready`. Saturating.
- `xfer_cnt`, output, `CNT_W`: completed output transfers. Wraps modulo 2^`CNT_W`.

## Operation
- Accept means `in_valid && in_ready`. Fire means `out_valid && out_ready`.
- Storage: main register `M`, plus skid register `S` when `SKID=1`. Occupancy state is EMPTY (0), ONE (1) or FULL (2; only when `SKID=1`).
- Outputs follow state: `out_valid = (state != EMPTY)`, `out_data = M`, `occupancy` = state encoding.

`SKID=1` transitions (evaluated each cycle when `reset` and `flush` are both low):
- EMPTY, accept: `M <= in_data`, go to ONE.
- ONE, accept and no fire: `S <= in_data`, go to FULL.
- ONE, fire and no accept: go to EMPTY.
- ONE, accept and fire: `M <= in_data`, stay in ONE.
- FULL, fire: `M <= S`, go to ONE. No accept is possible in FULL.
- Any state, no accept and no fire: hold.
- `in_ready` is a flop. Its next value is 1 iff the next state is not FULL.

`SKID=0`:
- `in_ready = !out_valid || out_ready`. This is combinational from `out_ready`.
- On accept, `M <= in_data` and state goes to ONE.
- On fire without accept, state goes to EMPTY.

Flush:
- Next state is EMPTY. `M` and `S` keep their stale contents, but `out_valid` drops.
- A payload accepted in the same cycle as `flush` is discarded. Upstream sees the handshake complete; the payload is dropped.
- A fire in the flush cycle is a valid transfer and counts in `xfer_cnt`.
- For `SKID=1`, `in_ready` becomes 1 in the next cycle.

Counters:
- Both counters are cleared only by `reset`; `flush` does not clear them.
- `stall_cnt` holds at all-ones once saturated.

Payload:
- Never modified, truncated or extended.
- Upstream must hold `in_data` and `in_valid` stable until accepted. The stage does not check this.

## Timing
- Latency: accept in cycle N gives `out_valid` in cycle N+1 with `out_data` equal to the accepted payload.
- Throughput: one transfer per cycle in both modes while downstream is ready.
- `SKID=1`:
  - No combinational path from `out_ready` to `in_ready`.
  - After a downstream stall, one extra payload is absorbed into `S`.
  - `in_ready` deasserts the cycle after FULL is reached.
- `SKID=0`: one-cycle bubble-free forwarding, but with a combinational `out_ready`→`in_ready` path.
- Reset values:
  - state EMPTY; `out_valid` 0; `occupancy` 0.
  - `M`, `S` and `out_data` all 0.
  - `stall_cnt` and `xfer_cnt` both 0.
  - `in_ready` is 1 for `SKID=1`. For `SKID=0` it evaluates to 1 because `out_valid` is 0.
- Inputs are ignored while `reset` is high.
- Reset mid-operation drops all held entries the same way flush does; counters clear.
- Simultaneous `reset` and `flush`: reset wins.

## Test plan
- **Streaming:** `SKID=1`, `out_ready=1`, `in_data` = 0x10, 0x11, 0x12 on consecutive cycles → same values on `out_data` one cycle later each; `occupancy` stays 1; `xfer_cnt` = 3; `stall_cnt` = 0.
- **Skid fill:** `SKID=1`, send 0xA then 0xB while `out_ready=0` → `occupancy` reaches 2 and `in_ready` = 0 the next cycle. Raise `out_ready` → 0xA then 0xB on consecutive cycles; `stall_cnt` = stalled cycles; `in_ready` returns to 1 one cycle after the first fire.
- **Flush:** `SKID=1`, FULL holding 0xC and 0xD; assert `flush` with `in_valid=1`, `in_data=0xE` → next cycle `out_valid` = 0, `occupancy` = 0, `in_ready` = 1; 0xE never appears on `out_data`.
- **Combinational backpressure:** `SKID=0`, `out_valid=1`; toggle `out_ready` → `in_ready` follows it in the same cycle; payload 0x5A held while `out_ready=0`.
- **Saturation and wrap:** `CNT_W=4`, 20 stall cycles → `stall_cnt` = 15. 17 transfers → `xfer_cnt` = 1.
- **Reset mid-stream:** assert `reset` with `occupancy` = 2 and `stall_cnt` = 7 → next cycle every output at its reset value; a subsequent accept of 0x33 appears on `out_data` one cycle later.
